// File: rtl/rat_ckpt_multi.sv
// rat_ckpt_multi: superscalar register alias table with internal branch
// checkpoints for the rename/dispatch stage.
//
// Each of the 32 architectural entries holds {p_addr, valid}. Up to
// NUM_RENAME destinations are renamed per cycle, with an intra-group bypass
// to later lanes. NUM_CDB broadcast ports wake entries whose mapping still
// matches. A ring of NUM_CKPT snapshots is kept coherent with the same
// wakeups, so a mispredict can restore the table directly.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cdb_broadcast      [NUM_CDB]          per-port broadcast strobe
//   cdb_aaddr          [NUM_CDB*5]        per-port architectural address
//   cdb_p_addr         [NUM_CDB*PW]       per-port physical tag
//   rename_we          [NUM_RENAME]       lane i renames rename_rd[i]
//   rename_rd          [NUM_RENAME*5]     destination per lane
//   rename_p           [NUM_RENAME*PW]    new physical tag per lane
//   rs1_s, rs2_s       [NUM_RENAME*5]     source registers per lane
//   rs1_rat, rs2_rat   [NUM_RENAME*(PW+1)] per lane {p_addr, valid}
//   ckpt_req           take a snapshot this cycle
//   ckpt_id            slot the snapshot goes to (ring tail)
//   ckpt_full          every slot is live
//   ckpt_free          release the oldest slot
//   resolve_mispred    restore the table from slot resolve_id
//   resolve_id         slot to restore
//
// Build option: define RAT_CDB_BYPASS_EN to let source reads observe
// same-cycle CDB wakeups; otherwise wakeups become visible a cycle later.
module rat_ckpt_multi #(
    parameter int ROB_DEPTH  = 32,
    parameter int NUM_RENAME = 2,
    parameter int NUM_CDB    = 2,
    parameter int NUM_CKPT   = 4,
    localparam int PW = $clog2(ROB_DEPTH + 32),
    localparam int CW = $clog2(NUM_CKPT),
    localparam int EW = PW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CDB-1:0]       cdb_broadcast,
    input  logic [NUM_CDB*5-1:0]     cdb_aaddr,
    input  logic [NUM_CDB*PW-1:0]    cdb_p_addr,
    input  logic [NUM_RENAME-1:0]    rename_we,
    input  logic [NUM_RENAME*5-1:0]  rename_rd,
    input  logic [NUM_RENAME*PW-1:0] rename_p,
    input  logic [NUM_RENAME*5-1:0]  rs1_s,
    input  logic [NUM_RENAME*5-1:0]  rs2_s,
    output logic [NUM_RENAME*EW-1:0] rs1_rat,
    output logic [NUM_RENAME*EW-1:0] rs2_rat,
    input  logic                     ckpt_req,
    output logic [CW-1:0]            ckpt_id,
    output logic                     ckpt_full,
    input  logic                     ckpt_free,
    input  logic                     resolve_mispred,
    input  logic [CW-1:0]            resolve_id
);

    localparam logic [CW-1:0] PTR_ONE  = CW'(1);
    localparam logic [CW:0]   CNT_ONE  = (CW+1)'(1);
    localparam logic [CW:0]   CNT_FULL = (CW+1)'(NUM_CKPT);

    logic [PW-1:0] tab_p  [32];
    logic [31:0]   tab_v;
    logic [PW-1:0] slot_p [NUM_CKPT][32];
    logic [31:0]   slot_v [NUM_CKPT];
    logic [CW-1:0] head, tail;
    logic [CW:0]   count;

    logic [31:0]   ren_hit;
    logic [PW-1:0] ren_p  [32];
    logic [PW-1:0] nxt_p  [32];
    logic [31:0]   nxt_v;
    logic [31:0]   slot_wv [NUM_CKPT];
    logic          take, free_ok, free_mis;
    logic [CW-1:0] head_mis, tail_mis, span_mis;

    function automatic logic cdb_hit(input logic [4:0] a, input logic [PW-1:0] p,
                                     input logic [NUM_CDB-1:0] bc,
                                     input logic [NUM_CDB*5-1:0] aa,
                                     input logic [NUM_CDB*PW-1:0] cp);
        cdb_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_CDB; k++)
            if (bc[k] && aa[k*5 +: 5] == a && cp[k*PW +: PW] == p)
                cdb_hit = 1'b1;
    endfunction

    // Later lanes overwrite earlier ones, so the highest lane wins a shared rd.
    always_comb begin
        ren_hit = '0;
        for (int unsigned a = 0; a < 32; a++) ren_p[a] = '0;
        for (int unsigned i = 0; i < NUM_RENAME; i++) begin
            if (rename_we[i] && rename_rd[i*5 +: 5] != '0) begin
                ren_hit[rename_rd[i*5 +: 5]] = 1'b1;
                ren_p[rename_rd[i*5 +: 5]]   = rename_p[i*PW +: PW];
            end
        end
    end

    // Rename overrides wakeup on the same entry.
    always_comb begin
        nxt_v = '0;
        for (int unsigned a = 0; a < 32; a++) begin
            nxt_p[a] = tab_p[a];
            nxt_v[a] = tab_v[a] | cdb_hit(5'(a), tab_p[a], cdb_broadcast, cdb_aaddr, cdb_p_addr);
            if (ren_hit[a]) begin
                nxt_p[a] = ren_p[a];
                nxt_v[a] = 1'b0;
            end
        end
        for (int unsigned s = 0; s < NUM_CKPT; s++) begin
            slot_wv[s] = '0;
            for (int unsigned a = 0; a < 32; a++)
                slot_wv[s][a] = slot_v[s][a] |
                    cdb_hit(5'(a), slot_p[s][a], cdb_broadcast, cdb_aaddr, cdb_p_addr);
        end
    end

    // On restore the slot at resolve_id stays live, so a zero span means the
    // ring wrapped all the way round and is full, never empty.
    always_comb begin
        take     = ckpt_req && (count != CNT_FULL);
        free_ok  = ckpt_free && (count != '0);
        free_mis = free_ok && (head != resolve_id);
        head_mis = free_mis ? head + PTR_ONE : head;
        tail_mis = resolve_id + PTR_ONE;
        span_mis = tail_mis - head_mis;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned a = 0; a < 32; a++) tab_p[a] <= '0;
            tab_v <= '1;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (resolve_mispred) begin
            for (int unsigned a = 0; a < 32; a++) tab_p[a] <= slot_p[resolve_id][a];
            tab_v <= slot_wv[resolve_id];
            head  <= head_mis;
            tail  <= tail_mis;
            count <= (span_mis == '0) ? CNT_FULL : {1'b0, span_mis};
        end else begin
            for (int unsigned a = 0; a < 32; a++) tab_p[a] <= nxt_p[a];
            tab_v <= nxt_v;
            if (take) tail <= tail + PTR_ONE;
            if (free_ok) head <= head + PTR_ONE;
            count <= count + (take ? CNT_ONE : '0) - (free_ok ? CNT_ONE : '0);
        end
    end

    // Snapshot storage needs no reset: a cleared count makes every slot dead.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_CKPT; s++) slot_v[s] <= slot_wv[s];
        if (!rst && !resolve_mispred && take) begin
            slot_p[tail] <= nxt_p;
            slot_v[tail] <= nxt_v;
        end
    end

    always_comb begin
        logic [4:0]    s;
        logic [PW-1:0] rp;
        logic          rv;
        rs1_rat = '0;
        rs2_rat = '0;
        s  = '0;
        rp = '0;
        rv = 1'b0;
        for (int unsigned i = 0; i < NUM_RENAME; i++) begin
            for (int unsigned q = 0; q < 2; q++) begin
                s  = (q == 0) ? rs1_s[i*5 +: 5] : rs2_s[i*5 +: 5];
                rp = tab_p[s];
                rv = tab_v[s];
`ifdef RAT_CDB_BYPASS_EN
                if (cdb_hit(s, rp, cdb_broadcast, cdb_aaddr, cdb_p_addr)) rv = 1'b1;
`endif
                for (int unsigned j = 0; j < i; j++) begin
                    if (rename_we[j] && rename_rd[j*5 +: 5] == s) begin
                        rp = rename_p[j*PW +: PW];
                        rv = 1'b0;
                    end
                end
                if (s == '0) begin
                    rp = '0;
                    rv = 1'b1;
                end
                if (q == 0) rs1_rat[i*EW +: EW] = {rp, rv};
                else        rs2_rat[i*EW +: EW] = {rp, rv};
            end
        end
    end

    assign ckpt_id   = tail;
    assign ckpt_full = (count == CNT_FULL);

endmodule

// File: tb/tb_rat_ckpt_multi.sv
// Bench for rat_ckpt_multi: directed scenarios followed by randomized
// traffic, all compared against a table/ring model held in plain arrays.
module tb_rat_ckpt_multi;

    localparam int PW = 6;
    localparam int EW = 7;
    localparam int NR = 2;
    localparam int NC = 2;
    localparam int NK = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NC-1:0]    cdb_broadcast;
    logic [NC*5-1:0]  cdb_aaddr;
    logic [NC*PW-1:0] cdb_p_addr;
    logic [NR-1:0]    rename_we;
    logic [NR*5-1:0]  rename_rd;
    logic [NR*PW-1:0] rename_p;
    logic [NR*5-1:0]  rs1_s, rs2_s;
    logic [NR*EW-1:0] rs1_rat, rs2_rat;
    logic             ckpt_req, ckpt_full, ckpt_free, resolve_mispred;
    logic [1:0]       ckpt_id, resolve_id;

    rat_ckpt_multi #(.ROB_DEPTH(32), .NUM_RENAME(NR), .NUM_CDB(NC), .NUM_CKPT(NK)) dut (
        .clk(clk), .rst(rst),
        .cdb_broadcast(cdb_broadcast), .cdb_aaddr(cdb_aaddr), .cdb_p_addr(cdb_p_addr),
        .rename_we(rename_we), .rename_rd(rename_rd), .rename_p(rename_p),
        .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_rat(rs1_rat), .rs2_rat(rs2_rat),
        .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_free(ckpt_free), .resolve_mispred(resolve_mispred), .resolve_id(resolve_id)
    );

    // stimulus for the current cycle
    bit we[NR]; int rd[NR]; int rp[NR]; int r1[NR]; int r2[NR];
    bit bc[NC]; int aa[NC]; int cp[NC];
    bit req, fre, mis; int rid;

    // reference model
    int m_p[32]; bit m_v[32];
    int s_p[NK][32]; bit s_v[NK][32];
    int head, tail, cnt;

    int total = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] ent(input int p, input bit v);
        return {p[5:0], v};
    endfunction

    task automatic idle();
        for (int i = 0; i < NR; i++) begin we[i] = 0; rd[i] = 0; rp[i] = 0; r1[i] = 0; r2[i] = 0; end
        for (int k = 0; k < NC; k++) begin bc[k] = 0; aa[k] = 0; cp[k] = 0; end
        req = 0; fre = 0; mis = 0; rid = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            rename_we[i]        = we[i];
            rename_rd[i*5 +: 5] = 5'(rd[i]);
            rename_p[i*PW +: PW] = 6'(rp[i]);
            rs1_s[i*5 +: 5]     = 5'(r1[i]);
            rs2_s[i*5 +: 5]     = 5'(r2[i]);
        end
        for (int k = 0; k < NC; k++) begin
            cdb_broadcast[k]       = bc[k];
            cdb_aaddr[k*5 +: 5]    = 5'(aa[k]);
            cdb_p_addr[k*PW +: PW] = 6'(cp[k]);
        end
        ckpt_req = req; ckpt_free = fre; resolve_mispred = mis; resolve_id = 2'(rid);
    endtask

    function automatic bit woke(input int a, input int p);
        for (int k = 0; k < NC; k++)
            if (bc[k] && aa[k] == a && cp[k] == p) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] mread(input int s, input int lane);
        int p; bit v;
        if (s == 0) return ent(0, 1);
        p = m_p[s]; v = m_v[s];
`ifdef RAT_CDB_BYPASS_EN
        if (woke(s, p)) v = 1;
`endif
        for (int j = 0; j < lane; j++)
            if (we[j] && rd[j] == s) begin p = rp[j]; v = 0; end
        return ent(p, v);
    endfunction

    task automatic model_advance();
        int np[32]; bit nv[32]; int hn; int c0;
        for (int a = 0; a < 32; a++) begin
            np[a] = m_p[a];
            nv[a] = m_v[a] | woke(a, m_p[a]);
        end
        for (int i = 0; i < NR; i++)
            if (we[i] && rd[i] != 0) begin np[rd[i]] = rp[i]; nv[rd[i]] = 0; end
        for (int s = 0; s < NK; s++)
            for (int a = 0; a < 32; a++)
                if (woke(a, s_p[s][a])) s_v[s][a] = 1;
        c0 = cnt;
        if (mis) begin
            hn = (fre && c0 > 0 && head != rid) ? (head + 1) % NK : head;
            for (int a = 0; a < 32; a++) begin m_p[a] = s_p[rid][a]; m_v[a] = s_v[rid][a]; end
            head = hn;
            tail = (rid + 1) % NK;
            cnt  = ((rid - hn + NK) % NK) + 1;   // live slots: oldest through restored one
        end else begin
            for (int a = 0; a < 32; a++) begin m_p[a] = np[a]; m_v[a] = nv[a]; end
            if (req && c0 < NK) begin
                for (int a = 0; a < 32; a++) begin s_p[tail][a] = np[a]; s_v[tail][a] = nv[a]; end
                tail = (tail + 1) % NK;
                cnt++;
            end
            if (fre && c0 > 0) begin head = (head + 1) % NK; cnt--; end
        end
    endtask

    task automatic settle();
        drive();
        #1;
        for (int i = 0; i < NR; i++) begin
            chk("rs1_rat", rs1_rat[i*EW +: EW], mread(r1[i], i));
            chk("rs2_rat", rs2_rat[i*EW +: EW], mread(r2[i], i));
        end
        chk("ckpt_id", ckpt_id, tail);
        chk("ckpt_full", ckpt_full, cnt == NK);
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic do_reset();
        idle();
        drive();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int a = 0; a < 32; a++) begin m_p[a] = 0; m_v[a] = 1; end
        head = 0; tail = 0; cnt = 0;
    endtask

    task automatic sweep();
        idle();
        for (int g = 0; g < 8; g++) begin
            r1[0] = g*4; r2[0] = g*4 + 1; r1[1] = g*4 + 2; r2[1] = g*4 + 3;
            cyc();
        end
    endtask

    initial begin
        rst = 1;
        idle();
        for (int s = 0; s < NK; s++)
            for (int a = 0; a < 32; a++) begin s_p[s][a] = 0; s_v[s][a] = 0; end
        do_reset();

        // reset state
        idle(); r1[0] = 5; settle();
        chk("reset_x5", rs1_rat[0 +: EW], ent(0, 1));
        chk("reset_full", ckpt_full, 0);
        chk("reset_id", ckpt_id, 0);
        advance();
        sweep();

        // same-cycle lane bypass
        idle(); we[0] = 1; rd[0] = 3; rp[0] = 40; r1[1] = 3; settle();
        chk("bypass_lane1", rs1_rat[EW +: EW], ent(40, 0));
        advance();

        // both lanes rename x3: higher lane wins
        idle(); we[0] = 1; rd[0] = 3; rp[0] = 40; we[1] = 1; rd[1] = 3; rp[1] = 41; cyc();
        idle(); r1[0] = 3; settle();
        chk("dual_rename_x3", rs1_rat[0 +: EW], ent(41, 0));
        advance();

        // CDB race with rename, then stale and matching wakeups
        idle(); we[0] = 1; rd[0] = 3; rp[0] = 41; bc[0] = 1; aa[0] = 3; cp[0] = 40; cyc();
        idle(); r1[0] = 3; bc[1] = 1; aa[1] = 3; cp[1] = 39; settle();
        chk("race_x3", rs1_rat[0 +: EW], ent(41, 0));
        advance();
        idle(); r1[0] = 3; bc[0] = 1; aa[0] = 3; cp[0] = 41; settle();
`ifndef RAT_CDB_BYPASS_EN
        chk("stale_cdb_x3", rs1_rat[0 +: EW], ent(41, 0));
`endif
        advance();
        idle(); r2[1] = 3; settle();
        chk("wake_x3", rs2_rat[EW +: EW], ent(41, 1));
        advance();

        // checkpoint restore
        idle(); we[0] = 1; rd[0] = 7; rp[0] = 50; req = 1; settle();
        chk("ckpt_id0", ckpt_id, 0);
        advance();
        idle(); we[1] = 1; rd[1] = 7; rp[1] = 51; bc[0] = 1; aa[0] = 7; cp[0] = 50; cyc();
        idle(); r1[0] = 7; settle();
        chk("pre_restore_x7", rs1_rat[0 +: EW], ent(51, 0));
        advance();
        idle(); mis = 1; rid = 0; req = 1; cyc();
        idle(); r1[0] = 7; settle();
        chk("restore_x7", rs1_rat[0 +: EW], ent(50, 1));
        chk("restore_tail", ckpt_id, 1);
        advance();
        idle(); fre = 1; cyc();
        sweep();

        // checkpoint overflow
        do_reset();
        for (int n = 0; n < 4; n++) begin
            idle(); req = 1; settle();
            chk("ovf_id", ckpt_id, n);
            advance();
        end
        idle(); req = 1; settle();
        chk("ovf_full", ckpt_full, 1);
        advance();
        idle(); settle();
        chk("ovf_dropped_id", ckpt_id, 0);
        advance();
        idle(); fre = 1; cyc();
        idle(); settle();
        chk("free_not_full", ckpt_full, 0);
        advance();
        idle(); mis = 1; rid = 2; cyc();
        idle(); req = 1; settle();
        chk("mis2_tail", ckpt_id, 3);
        chk("mis2_count2", ckpt_full, 0);
        advance();
        idle(); req = 1; settle();
        chk("mis2_count3", ckpt_full, 0);
        advance();
        idle(); settle();
        chk("mis2_count4", ckpt_full, 1);
        advance();

        // randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            idle();
            for (int i = 0; i < NR; i++) begin
                we[i] = ($urandom_range(0, 9) < 6);
                rd[i] = $urandom_range(0, 7);
                rp[i] = $urandom_range(0, 63);
                r1[i] = $urandom_range(0, 7);
                r2[i] = $urandom_range(0, 7);
            end
            for (int k = 0; k < NC; k++) begin
                int pick;
                bc[k] = $urandom_range(0, 1);
                aa[k] = $urandom_range(0, 7);
                pick = $urandom_range(0, 2);
                if (pick == 0) cp[k] = m_p[aa[k]];
                else if (pick == 1) cp[k] = s_p[$urandom_range(0, NK-1)][aa[k]];
                else cp[k] = $urandom_range(0, 63);
            end
            req = ($urandom_range(0, 9) < 3);
            fre = ($urandom_range(0, 9) < 2);
            if (cnt > 0 && $urandom_range(0, 11) == 0) begin
                mis = 1;
                rid = (head + $urandom_range(0, cnt - 1)) % NK;
            end
            cyc();
        end
        sweep();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
